// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern sequencer: FSM state encoding,
// channel-select priority and frame timing.
package pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        END
    } state_t;

    // Widest select vector the priority helper accepts.
    localparam int unsigned SEL_MAX = 32;

    function automatic int unsigned lowest_set_index(input logic [SEL_MAX-1:0] sel);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < SEL_MAX; i++) begin
            if (sel[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned dw, input int unsigned baud_div);
        return (dw + 2) * baud_div;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Board-side bundle of the pattern sequencer: switches, triggers, ROM bus,
// serial line and status.
interface pattern_sequencer_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 4
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    sel;
    logic              write;
    logic              auto;
    logic [AW-1:0]     rom_addr;
    logic [NCH*DW-1:0] rom_data;
    logic              ser_out;
    logic              busy;
    logic              done;
    logic [DW-1:0]     data_latch;
    logic [CW-1:0]     chan;

    modport slave (
        input  sel, write, auto, rom_data,
        output rom_addr, ser_out, busy, done, data_latch, chan
    );

    modport master (
        output sel, write, auto, rom_data,
        input  rom_addr, ser_out, busy, done, data_latch, chan
    );

endinterface

// File: rtl/ser_shift.sv
// Serial frame engine: baud counter, data-bit counter and LSB-first shift
// register, sequenced by the controller's current state.
module ser_shift
    import pattern_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  state_t        phase,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic          ser_out,
    output logic          baud_end,
    output logic          bit_last,
    output logic          frame_done
);

    localparam int unsigned BW  = $clog2(BAUD_DIV);
    localparam int unsigned BCW = (DW > 1) ? $clog2(DW) : 1;

    logic [BW-1:0]  baud_q, baud_d;
    logic [BCW-1:0] bit_q, bit_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic           in_frame;

    assign in_frame   = (phase == START) || (phase == DATA) || (phase == STOP);
    assign baud_end   = (baud_q == BW'(BAUD_DIV - 1));
    assign bit_last   = (bit_q == BCW'(DW - 1));
    assign frame_done = (phase == STOP) && baud_end;

    // Every state change happens on a baud boundary, so wrapping at baud_end
    // also restarts the counter on each transition.
    always_comb begin
        baud_d = '0;
        if (in_frame && !baud_end) begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_comb begin
        bit_d = '0;
        if (phase == DATA) begin
            bit_d = bit_q;
            if (baud_end) begin
                bit_d = bit_last ? '0 : bit_q + 1'b1;
            end
        end
    end

    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = din;
        end else if ((phase == DATA) && baud_end) begin
            shift_d = shift_q >> 1;
        end
    end

    always_comb begin
        ser_out = 1'b1;
        case (phase)
            START:   ser_out = 1'b0;
            DATA:    ser_out = shift_q[0];
            default: ser_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer top: picks a channel from the switches, walks LEN ROM
// words and hands each one to the serial frame engine.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 4,
    parameter int unsigned LEN      = 16,
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic                sysclk,
    input  logic                reset,
    pattern_sequencer_if.slave  bus
);

    localparam int unsigned   CW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] latch_q, latch_d;
    logic          write_q, write_d;

    logic [DW-1:0] rom_word;
    logic          sel_any;
    logic [CW-1:0] sel_idx;
    logic          start_req;
    logic          load;
    logic          baud_end;
    logic          bit_last;
    logic          frame_done;

    assign write_d   = bus.write;
    assign sel_any   = |bus.sel;
    assign sel_idx   = CW'(lowest_set_index(SEL_MAX'(bus.sel)));
    // A write edge with no channel selected is consumed here and never queued.
    assign start_req = ((bus.write && !write_q) || bus.auto) && sel_any;
    assign load      = (state_q == LOAD);

    always_comb begin
        rom_word = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (chan_q == CW'(k)) begin
                rom_word = bus.rom_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        latch_d = latch_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    chan_d  = sel_idx;
                    addr_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                latch_d = rom_word;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end && bit_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (frame_done) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = END;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            END: begin
                if (bus.auto && sel_any) begin
                    chan_d  = sel_idx;
                    addr_d  = '0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            chan_q  <= '0;
            addr_q  <= '0;
            latch_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            latch_q <= latch_d;
            write_q <= write_d;
        end
    end

    ser_shift #(
        .DW       (DW),
        .BAUD_DIV (BAUD_DIV)
    ) u_ser_shift (
        .clk        (sysclk),
        .rst        (reset),
        .phase      (state_q),
        .load       (load),
        .din        (rom_word),
        .ser_out    (bus.ser_out),
        .baud_end   (baud_end),
        .bit_last   (bit_last),
        .frame_done (frame_done)
    );

    assign bus.rom_addr   = addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == END);
    assign bus.data_latch = latch_q;
    assign bus.chan       = chan_q;

endmodule
